// File: rtl/uart_defs_pkg.sv
// Shared UART constants and transmitter state encodings (also used by the receive path).
package uart_defs_pkg;

    localparam int unsigned CLK_FREQ_HZ  = 50_000_000;
    localparam int unsigned BAUD         = 115_200;
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;  // 434
    localparam int unsigned DATA_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered write and show-ahead read data.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // Writes while full and reads while empty are dropped without side effects.
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset flushes the contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1/8N2 serializer.
// tx comes straight from a flop; the baud counter restarts at every frame.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = uart_defs_pkg::CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned STOP_BITS    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_done
);

    import uart_defs_pkg::*;

    if ((STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLKS_PER_BIT < 2) begin : g_bad_params
        $error("uart_tx_fifo: illegal parameter combination");
    end

    localparam int unsigned   CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;

    logic [7:0] fifo_rd_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       tick;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign tick     = (cnt_q == CNT_MAX);
    assign tx_ready = !fifo_full;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign tx       = tx_q;

    // Next-state logic: frame sequencing, bit timing and FIFO pops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (bit_q == LAST_STOP) begin
                        // Last cycle of the frame: chain the next byte with no gap.
                        tx_done = 1'b1;
                        bit_d   = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_rd_data;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the next cycle, derived from the next state so tx is a plain flop.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State register; reset truncates any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a frame-position reference model
// plus an independent mid-bit sampling serial decoder.
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 6;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned STOPB = 2;
    localparam int          FRAME = (1 + 8 + STOPB) * CPB;
    localparam int          CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          tx_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queued bytes, byte on the wire, position within its frame (-1 idle).
    byte unsigned mq[$];
    byte unsigned cur;
    int           pos = -1;

    // Serial decoder state.
    int           rx_t = -1;
    byte unsigned rx_byte;
    byte unsigned rx_q[$];
    int           done_cnt = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .STOP_BITS    (STOPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .tx_done    (tx_done)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs presented to that edge.
    task automatic model_edge();
        bit can_push;
        bit can_pop;
        if (rst) begin
            mq.delete();
            pos = -1;
            return;
        end
        can_push = tx_valid && (mq.size() < DEPTH);
        can_pop  = (pos == -1 || pos == FRAME - 1) && (mq.size() != 0);
        if (pos != -1 && pos != FRAME - 1) begin
            pos++;
        end else if (can_pop) begin
            cur = mq.pop_front();
            pos = 0;
        end else begin
            pos = -1;
        end
        if (can_push) mq.push_back(tx_data);
    endtask

    function automatic logic exp_tx();
        int b;
        if (pos < 0) return 1'b1;
        b = pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    task automatic rx_sample();
        int k;
        if (rst) begin
            rx_t = -1;
            return;
        end
        if (rx_t < 0) begin
            if (tx == 1'b0) rx_t = 0;
            else return;
        end else begin
            rx_t++;
        end
        if (rx_t % CPB == CPB / 2) begin
            k = rx_t / CPB;
            if (k >= 1 && k <= 8) rx_byte[k-1] = tx;
            if (k == 9) begin
                rx_q.push_back(rx_byte);
                rx_t = -1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("tx", tx, exp_tx());
        check("tx_done", tx_done, pos == FRAME - 1);
        check("busy", busy, (pos != -1) || (mq.size() != 0));
        check("fifo_count", fifo_count, mq.size());
        check("tx_ready", tx_ready, mq.size() != DEPTH);
        if (tx_done === 1'b1) done_cnt++;
        rx_sample();
    endtask

    task automatic push(input byte unsigned d);
        bit acc;
        int g;
        g        = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        do begin
            acc = tx_ready;
            step();
            g++;
        end while (!acc && g < 4 * FRAME);
        if (!acc) check("push_timeout", 0, 1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((pos != -1 || mq.size() != 0) && g < (DEPTH + 4) * FRAME) begin
            step();
            g++;
        end
        step();
        check("drain_busy", busy, 0);
    endtask

    task automatic compare_rx(input string tag, input byte unsigned exp[$]);
        check({tag, "_len"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            check(tag, rx_q[i], exp[i]);
        end
    endtask

    initial begin
        byte unsigned exp_b[$];
        byte unsigned d;
        bit           a;
        int           acc_n;
        int           g;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_tx", tx, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_done", tx_done, 0);

        // Single byte: start bit appears one edge after acceptance.
        done_cnt = 0;
        rx_q.delete();
        push(8'h55);
        check("lat_idle", tx, 1);
        step();
        check("lat_start", tx, 0);
        wait_idle();
        check("single_done_cnt", done_cnt, 1);
        exp_b = '{8'h55};
        compare_rx("single_rx", exp_b);

        // Two bytes back to back: second start bit right after tx_done.
        rx_q.delete();
        push(8'hA3);
        push(8'h0F);
        g = 0;
        while (tx_done !== 1'b1 && g < 2 * FRAME) begin
            step();
            g++;
        end
        check("b2b_done_seen", tx_done, 1);
        step();
        check("b2b_start", tx, 0);
        wait_idle();
        exp_b = '{8'hA3, 8'h0F};
        compare_rx("b2b_rx", exp_b);

        // Stream 20 bytes with valid held; FIFO fills after 17 accepts.
        rx_q.delete();
        exp_b.delete();
        acc_n    = 0;
        g        = 0;
        tx_valid = 1'b1;
        while (acc_n < 20 && g < 30 * FRAME) begin
            tx_data = 8'(acc_n);
            a       = tx_ready;
            step();
            g++;
            if (a) begin
                exp_b.push_back(8'(acc_n));
                acc_n++;
                if (acc_n == 17) begin
                    check("full_count", fifo_count, 16);
                    check("full_ready", tx_ready, 0);
                end
            end
        end
        tx_valid = 1'b0;
        check("stream_accepts", acc_n, 20);
        wait_idle();
        compare_rx("stream_rx", exp_b);

        // Push coinciding with a pop at fifo_count=15.
        rx_q.delete();
        exp_b.delete();
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            push(d);
            exp_b.push_back(d);
        end
        check("pp_pre_count", fifo_count, 15);
        g = 0;
        while (pos != FRAME - 1 && g < 2 * FRAME) begin
            step();
            g++;
        end
        d        = 8'($urandom);
        tx_valid = 1'b1;
        tx_data  = d;
        step();
        tx_valid = 1'b0;
        exp_b.push_back(d);
        check("pp_count", fifo_count, 15);
        wait_idle();
        compare_rx("pp_rx", exp_b);

        // Reset during data bit 3 with 5 bytes queued.
        rx_q.delete();
        for (int i = 0; i < 6; i++) push(8'($urandom));
        g = 0;
        while (pos != 4 * CPB + 2 && g < 2 * FRAME) begin
            step();
            g++;
        end
        check("mid_queued", fifo_count, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", tx_ready, 1);
        done_cnt = 0;
        repeat (2 * FRAME) step();
        check("mid_no_frames", done_cnt, 0);
        check("mid_no_rx", rx_q.size(), 0);

        // Loopback of corner byte values.
        rx_q.delete();
        exp_b = '{8'h00, 8'hFF, 8'h80, 8'h01};
        foreach (exp_b[i]) push(exp_b[i]);
        wait_idle();
        compare_rx("loop_rx", exp_b);

        // Random bytes with random producer gaps.
        rx_q.delete();
        exp_b.delete();
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 7) == 0) repeat (FRAME) step();
            push(d);
            exp_b.push_back(d);
        end
        wait_idle();
        compare_rx("rand_rx", exp_b);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
